// File: rtl/sha256_bist_driver.sv
// sha256_bist_driver
// Self-test sequencer for sha256_core. Pseudo-random 512-bit blocks come from a
// 32-bit Galois LFSR. The core is driven through NUM_TESTS messages of
// BLOCKS_PER_TEST blocks each. The final digest of each message is folded into
// a 256-bit MISR signature.
// Optional build macro: SHA256_BIST_MODE_SWEEP_EN alternates core_mode between
// MODE and !MODE on successive messages. When the macro is undefined, core_mode
// stays at MODE.
module sha256_bist_driver #(
    parameter int unsigned  NUM_TESTS       = 3,
    parameter int unsigned  BLOCKS_PER_TEST = 1,
    parameter logic [31:0]  LFSR_SEED       = 32'h0000_0001,
    parameter int unsigned  TIMEOUT_CYCLES  = 200,
    parameter logic         MODE            = 1'b1,
    parameter logic [255:0] EXPECTED_SIG    = 256'h0,
    parameter logic         CHECK_SIG       = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         err_timeout,
    output logic         err_invalid,
    output logic [15:0]  test_count,
    output logic [255:0] signature,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    input  logic         core_digest_valid
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]  state;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [3:0]  fill_cnt;
    logic [31:0] blk_idx;
    logic [31:0] timer;
    logic        last_block;
    logic        more_tests;
    logic        timed_out;

    assign lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'hA300_0000 : 32'h0);
    assign last_block = (blk_idx == BLOCKS_PER_TEST - 1);
    assign more_tests = ({16'h0, test_count} + 32'd1) < NUM_TESTS;
    assign timed_out  = (timer >= TIMEOUT_CYCLES);

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign core_init = (state == S_ISSUE) && (blk_idx == 32'd0);
    assign core_next = (state == S_ISSUE) && (blk_idx != 32'd0);
    assign pass      = done && !err_timeout && !err_invalid &&
                       (!CHECK_SIG || (signature == EXPECTED_SIG));

`ifdef SHA256_BIST_MODE_SWEEP_EN
    // test_count only moves between messages, so the mode holds for a whole message
    assign core_mode = MODE ^ test_count[0];
`else
    assign core_mode = MODE;
`endif

    // Run sequencer: block fill, issue, core handshake, timeout and signature fold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            lfsr        <= '0;
            fill_cnt    <= '0;
            blk_idx     <= '0;
            timer       <= '0;
            core_block  <= '0;
            signature   <= '0;
            test_count  <= '0;
            err_timeout <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample pre-edge values
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_FILL;
                        lfsr        <= LFSR_SEED;
                        fill_cnt    <= '0;
                        blk_idx     <= '0;
                        signature   <= '0;
                        test_count  <= '0;
                        err_timeout <= 1'b0;
                        err_invalid <= 1'b0;
                    end
                end
                S_FILL: begin
                    lfsr       <= lfsr_next;
                    core_block <= {core_block[479:0], lfsr_next};
                    fill_cnt   <= fill_cnt + 4'd1;
                    if (fill_cnt == 4'd15) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    timer <= 32'd1;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!core_ready) begin
                        timer <= timer + 32'd1;
                        state <= S_WAIT_DONE;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (core_ready) begin
                        if (!core_digest_valid) begin
                            err_invalid <= 1'b1;
                            state       <= S_DONE;
                        end else if (!last_block) begin
                            blk_idx <= blk_idx + 32'd1;
                            state   <= S_FILL;
                        end else begin
                            signature  <= {signature[254:0], signature[255]} ^ core_digest;
                            test_count <= test_count + 16'd1;
                            blk_idx    <= '0;
                            state      <= more_tests ? S_FILL : S_DONE;
                        end
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_bist_driver.sv
// tb_sha256_bist_driver
// Drives three driver instances against behavioural sha256_core stand-ins.
// Instance A runs 3 messages of 2 blocks each, with a signature check against a reference model.
// Instances B and C run 2 one-block messages with a constant digest of 1.
// B expects a golden signature of 3 and C expects 2. B and C also exercise the 50-cycle timeout.
module tb_sha256_bist_driver;

    localparam int A_TESTS = 3;
    localparam int A_BPT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_bc = 1'b0;

    logic a_busy, a_done, a_pass, a_err_to, a_err_inv, a_init, a_next, a_mode;
    logic [15:0]  a_tc;
    logic [255:0] a_sig;
    logic [511:0] a_block;
    logic         a_ready, a_dvalid;
    logic [255:0] a_digest;

    logic b_busy, b_done, b_pass, b_err_to, b_err_inv, b_init, b_next, b_mode;
    logic [15:0]  b_tc;
    logic [255:0] b_sig;
    logic [511:0] b_block;
    logic         b_ready;

    logic c_busy, c_done, c_pass, c_err_to, c_err_inv, c_init, c_next, c_mode;
    logic [15:0]  c_tc;
    logic [255:0] c_sig;
    logic [511:0] c_block;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sha256_bist_driver #(
        .NUM_TESTS(A_TESTS), .BLOCKS_PER_TEST(A_BPT), .LFSR_SEED(32'h0000_0001),
        .TIMEOUT_CYCLES(200), .MODE(1'b1), .EXPECTED_SIG(256'h0), .CHECK_SIG(1'b0)
    ) u_a (
        .clk(clk), .reset(rst), .start(start_a), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_timeout(a_err_to), .err_invalid(a_err_inv), .test_count(a_tc), .signature(a_sig),
        .core_init(a_init), .core_next(a_next), .core_mode(a_mode), .core_block(a_block),
        .core_ready(a_ready), .core_digest(a_digest), .core_digest_valid(a_dvalid)
    );

    sha256_bist_driver #(
        .NUM_TESTS(2), .BLOCKS_PER_TEST(1), .LFSR_SEED(32'h0000_0001),
        .TIMEOUT_CYCLES(50), .MODE(1'b1), .EXPECTED_SIG(256'h3), .CHECK_SIG(1'b1)
    ) u_b (
        .clk(clk), .reset(rst), .start(start_bc), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_timeout(b_err_to), .err_invalid(b_err_inv), .test_count(b_tc), .signature(b_sig),
        .core_init(b_init), .core_next(b_next), .core_mode(b_mode), .core_block(b_block),
        .core_ready(b_ready), .core_digest(256'h1), .core_digest_valid(1'b1)
    );

    sha256_bist_driver #(
        .NUM_TESTS(2), .BLOCKS_PER_TEST(1), .LFSR_SEED(32'h0000_0001),
        .TIMEOUT_CYCLES(50), .MODE(1'b1), .EXPECTED_SIG(256'h2), .CHECK_SIG(1'b1)
    ) u_c (
        .clk(clk), .reset(rst), .start(start_bc), .busy(c_busy), .done(c_done), .pass(c_pass),
        .err_timeout(c_err_to), .err_invalid(c_err_inv), .test_count(c_tc), .signature(c_sig),
        .core_init(c_init), .core_next(c_next), .core_mode(c_mode), .core_block(c_block),
        .core_ready(b_ready), .core_digest(256'h1), .core_digest_valid(1'b1)
    );

    // Core stand-in A: ready drops after a request and returns after a_lat cycles.
    // The digest is a salted fold of the block. The message index a_bad_abs reports no digest.
    int           a_lat     = 66;
    int           a_bad_abs = -1;
    logic [255:0] a_salt    = '0;
    int           a_cnt;
    int           a_inits   = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ready  <= 1'b1;
            a_cnt    <= 0;
            a_digest <= '0;
            a_dvalid <= 1'b1;
        end else if (a_init || a_next) begin
            a_ready  <= 1'b0;
            a_cnt    <= (a_lat != 0) ? a_lat - 1 : int'($urandom_range(29, 0));
            a_digest <= a_block[511:256] ^ a_block[255:0] ^ a_salt;
            a_dvalid <= ((a_init ? a_inits : a_inits - 1) != a_bad_abs);
            if (a_init) a_inits <= a_inits + 1;
        end else if (!a_ready) begin
            if (a_cnt == 0) a_ready <= 1'b1;
            else a_cnt <= a_cnt - 1;
        end
    end

    // Core stand-in B (shared by B and C): random latency, or no completion at all when b_never is set
    bit b_never = 1'b0;
    int b_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            b_ready <= 1'b1;
            b_cnt   <= 0;
        end else if (b_init || b_next) begin
            b_ready <= 1'b0;
            b_cnt   <= int'($urandom_range(29, 0));
        end else if (!b_ready && !b_never) begin
            if (b_cnt == 0) b_ready <= 1'b1;
            else b_cnt <= b_cnt - 1;
        end
    end

    // Issue monitor: counts request pulses and records mode and block at each issue
    int   a_init_seen = 0, a_next_seen = 0, a_pulse_err = 0, b_init_seen = 0, c_init_seen = 0;
    logic a_init_prev = 1'b0;
    logic         a_issue_mode[$];
    logic [511:0] a_init_blocks[$];
    always @(negedge clk) begin
        if (a_init) begin
            a_init_seen++;
            a_issue_mode.push_back(a_mode);
            a_init_blocks.push_back(a_block);
        end
        if (a_next) begin
            a_next_seen++;
            a_issue_mode.push_back(a_mode);
        end
        if (a_init && a_init_prev) a_pulse_err++;
        a_init_prev = a_init;
        if (b_init) b_init_seen++;
        if (c_init) c_init_seen++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? 32'hA300_0000 : 32'h0);
    endfunction

    function automatic logic exp_mode(input int t);
`ifdef SHA256_BIST_MODE_SWEEP_EN
        return (t % 2 == 0) ? 1'b1 : 1'b0;
`else
        return (t >= 0) ? 1'b1 : 1'b1;
`endif
    endfunction

    // Reference run: generates every block from the LFSR rule and folds message digests
    task automatic ref_run(input logic [31:0] seed, input int ntests, input int bpt,
                           input logic [255:0] salt, input bit one_digest, input int bad_test,
                           output logic [255:0] sig, output int tcount, output int inits,
                           output int nexts, output bit inv);
        logic [31:0]  q;
        logic [511:0] blk;
        logic [255:0] dig;
        q = seed; sig = '0; tcount = 0; inits = 0; nexts = 0; inv = 1'b0;
        for (int t = 0; t < ntests; t++) begin
            for (int b = 0; b < bpt; b++) begin
                blk = '0;
                for (int w = 0; w < 16; w++) begin
                    q = lfsr_step(q);
                    blk[511 - 32*w -: 32] = q;
                end
                if (b == 0) inits++; else nexts++;
                if (t == bad_test) begin
                    inv = 1'b1;
                    return;
                end
                dig = one_digest ? 256'h1 : (blk[511:256] ^ blk[255:0] ^ salt);
                if (b == bpt - 1) begin
                    sig = {sig[254:0], sig[255]} ^ dig;
                    tcount++;
                end
            end
        end
    endtask

    task automatic pulse_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_bc();
        @(posedge clk); #1 start_bc = 1'b1;
        @(posedge clk); #1 start_bc = 1'b0;
    endtask

    task automatic wait_a(input string tag, input int budget, output int n);
        n = 0;
        while (!a_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 256'(a_done), 256'(1));
    endtask

    task automatic wait_b(input string tag, input int budget, output int n);
        n = 0;
        while (!b_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 256'(b_done), 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] e_sig;
        logic [511:0] blk;
        int e_tc, e_i, e_n, n, bi, bn, bq, bb, k;
        bit e_inv;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_flags", 256'({a_busy, a_done, a_pass, a_err_to, a_err_inv, a_init, a_next}), 256'(0));
        check("rst_mode", 256'(a_mode), 256'(1));
        check("rst_data", a_sig ^ 256'(a_tc) ^ a_block[511:256] ^ a_block[255:0], 256'(0));
        rst = 1'b0;

        // Seed-1 block words, 66-cycle core latency, 3 messages x 2 blocks
        bi = a_init_seen; bn = a_next_seen; bq = a_issue_mode.size(); bb = a_init_blocks.size();
        for (int i = 0; i < 8; i++) a_salt[32*i +: 32] = $urandom();
        a_lat = 66;
        pulse_a();
        wait_a("s1", 3000, n);
        ref_run(32'h1, A_TESTS, A_BPT, a_salt, 1'b0, -1, e_sig, e_tc, e_i, e_n, e_inv);
        blk = a_init_blocks[bb];
        check("s1_word0", 256'(blk[511:480]), 256'(32'hA300_0000));
        check("s1_word1", 256'(blk[479:448]), 256'(32'h5180_0000));
        check("s1_inits", 256'(a_init_seen - bi), 256'(e_i));
        check("s1_nexts", 256'(a_next_seen - bn), 256'(e_n));
        check("s1_count", 256'(a_tc), 256'(e_tc));
        check("s1_sig", a_sig, e_sig);
        check("s1_errs", 256'({a_err_to, a_err_inv, a_busy}), 256'(0));
        check("s1_pass", 256'(a_pass), 256'(1));
        check("s1_init_width", 256'(a_pulse_err), 256'(0));
        for (int i = 0; i < A_TESTS * A_BPT; i++)
            check($sformatf("s1_mode%0d", i), 256'(a_issue_mode[bq + i]), 256'(exp_mode(i / A_BPT)));

        // Random latencies and salts, with an ignored start pulse mid-run
        a_lat = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) a_salt[32*i +: 32] = $urandom();
            bi = a_init_seen;
            k = int'($urandom_range(80, 3));
            pulse_a();
            repeat (k) @(negedge clk);
            check($sformatf("s2_busy%0d", r), 256'(a_busy), 256'(1));
            pulse_a();
            wait_a($sformatf("s2_%0d", r), 3000, n);
            ref_run(32'h1, A_TESTS, A_BPT, a_salt, 1'b0, -1, e_sig, e_tc, e_i, e_n, e_inv);
            check($sformatf("s2_sig%0d", r), a_sig, e_sig);
            check($sformatf("s2_count%0d", r), 256'(a_tc), 256'(e_tc));
            check($sformatf("s2_inits%0d", r), 256'(a_init_seen - bi), 256'(e_i));
        end

        // Second message reports ready without a valid digest
        a_lat = 5;
        a_bad_abs = a_inits + 1;
        bi = a_init_seen; bn = a_next_seen;
        pulse_a();
        wait_a("s3", 3000, n);
        ref_run(32'h1, A_TESTS, A_BPT, a_salt, 1'b0, 1, e_sig, e_tc, e_i, e_n, e_inv);
        check("s3_err_inv", 256'(a_err_inv), 256'(e_inv));
        check("s3_err_to", 256'(a_err_to), 256'(0));
        check("s3_count", 256'(a_tc), 256'(e_tc));
        check("s3_sig", a_sig, e_sig);
        check("s3_pass", 256'(a_pass), 256'(0));
        check("s3_issues", 256'({16'(a_init_seen - bi), 16'(a_next_seen - bn)}), 256'({16'(e_i), 16'(e_n)}));
        a_bad_abs = -1;

        // Reset during FILL aborts with every output cleared
        pulse_a();
        repeat (5) @(negedge clk);
        check("s4_busy_fill", 256'(a_busy), 256'(1));
        #2 rst = 1'b1;
        #1 check("s4_async", 256'({a_busy, a_done, a_pass, a_err_to, a_err_inv, a_init, a_next}), 256'(0));
        @(posedge clk); #1;
        check("s4_block", a_block[511:256] | a_block[255:0], 256'(0));
        check("s4_data", a_sig ^ 256'(a_tc), 256'(0));
        @(negedge clk) rst = 1'b0;
        bi = a_init_seen;
        repeat (40) @(negedge clk);
        check("s4_no_init", 256'(a_init_seen - bi), 256'(0));
        check("s4_idle", 256'({a_busy, a_done}), 256'(0));

        // Constant digest 1 over 2 messages: golden 3 passes, golden 2 fails
        pulse_bc();
        wait_b("s5", 2000, n);
        ref_run(32'h1, 2, 1, 256'h0, 1'b1, -1, e_sig, e_tc, e_i, e_n, e_inv);
        check("s5_b_sig", b_sig, e_sig);
        check("s5_b_pass", 256'(b_pass), 256'(1));
        check("s5_c_sig", c_sig, e_sig);
        check("s5_c_pass", 256'(c_pass), 256'(0));
        check("s5_counts", 256'({b_tc, c_tc}), 256'({16'(e_tc), 16'(e_tc)}));
        check("s5_c_errs", 256'({c_err_to, c_err_inv, c_next, c_busy, c_done}), 256'(1));
        check("s5_c_block", c_block[511:256] ^ c_block[255:0] ^ 256'(c_mode), b_block[511:256] ^ b_block[255:0] ^ 256'(b_mode));

        // Core never completes: timeout after 50 cycles, one init only
        b_never = 1'b1;
        bi = b_init_seen; bn = c_init_seen;
        pulse_bc();
        wait_b("s6", 300, n);
        check("s6_err_to", 256'({b_err_to, c_err_to}), 256'(2'b11));
        check("s6_err_inv", 256'({b_err_inv, b_next}), 256'(0));
        check("s6_pass", 256'({b_pass, c_pass}), 256'(0));
        check("s6_count", 256'(b_tc), 256'(0));
        check("s6_inits", 256'({16'(b_init_seen - bi), 16'(c_init_seen - bn)}), 256'({16'd1, 16'd1}));
        check("s6_latency", 256'(n >= 60 && n <= 80), 256'(1));
        b_never = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
